pin_bus_sequencer: RTL
======================

PIN_BUS_SEQUENCER -- requirements
Module: pin_bus_sequencer

Interface
REQ-001 SHALL have parameter NPINS, default 4, number of shared bidirectional pads.
REQ-002 SHALL have parameter DRIVE_CYCLES, default 4, cycles pads are driven per write (>=1).
REQ-003 SHALL have parameter TURN_CYCLES, default 2, bus-turnaround cycles with OE low after a drive (>=1).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 3, wait cycles before a read capture (>=1).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports wr_valid input 1, wr_ready output 1, wr_data input NPINS: write request handshake.
REQ-008 SHALL have ports rd_valid input 1, rd_ready output 1: read request handshake.
REQ-009 SHALL have ports rsp_valid output 1, rsp_data output NPINS: read response, single-cycle pulse, no backpressure.
REQ-010 SHALL have ports pad_oe output NPINS, pad_dout output NPINS, pad_din input NPINS: to SB_IO OUTPUT_ENABLE, D_OUT_0, D_IN_0.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, DRIVE, TURN, SETTLE; single down-counter of width $clog2(max(DRIVE,TURN,SETTLE)+1) times each state.
REQ-013 wr_ready and rd_ready SHALL be high only in IDLE, and at most one SHALL be high per cycle (grant).
REQ-014 In IDLE with only one requester pending, that requester SHALL be granted; with neither, no grant.
REQ-015 With wr_valid and rd_valid both high in IDLE, grant SHALL alternate: the requester not served by the last accepted transfer wins; after reset write wins first.
REQ-016 Write accepted at cycle T (wr_valid&wr_ready): pad_dout SHALL hold wr_data and pad_oe all-ones from T+1 to T+DRIVE_CYCLES inclusive.
REQ-017 After DRIVE, TURN SHALL hold pad_oe=0 for TURN_CYCLES; pad_dout SHALL keep last value; return to IDLE at T+DRIVE_CYCLES+TURN_CYCLES+1.
REQ-018 pad_oe SHALL be all-zero in every state except DRIVE; no pad SHALL be driven in the cycle a read captures.
REQ-019 pad_din SHALL pass through a 2-flop synchronizer (reset 0) before any use.
REQ-020 Read accepted at cycle T: SETTLE for SETTLE_CYCLES, then rsp_data SHALL equal synchronized pad_din and rsp_valid=1 for exactly cycle T+SETTLE_CYCLES+1, IDLE same cycle.
REQ-021 rsp_data SHALL hold its last captured value while rsp_valid is low.
REQ-022 A read granted immediately after a write's TURN SHALL still observe full SETTLE_CYCLES; no request SHALL be accepted outside IDLE.
REQ-023 wr_data SHALL be sampled only on the accept cycle; later changes SHALL not affect pad_dout.

Reset
REQ-024 resetn low SHALL immediately force pad_oe=0, pad_dout=0, rsp_valid=0, rsp_data=0, wr_ready=0, rd_ready=0, busy=0, state IDLE, counter 0, priority=write, synchronizer 0.
REQ-025 Reset asserted mid-DRIVE SHALL release pads asynchronously (pad_oe=0 without waiting for clk); the aborted transfer SHALL produce no response.
REQ-026 Deassertion SHALL be synchronized externally; first grant possible on the first rising edge after release.

Structure
REQ-027 State encoding enum and default timing constants SHALL live in shared package pin_bus_pkg.
REQ-028 Synchronizer SHALL be a separate sub-module pin_sync2 (parameter WIDTH); SB_IO instances SHALL remain outside this block.

Verification
REQ-029 Write 4'b1010 at T with defaults -> pad_oe=4'b1111, pad_dout=4'b1010 cycles T+1..T+4; pad_oe=0 T+5..T+6; wr_ready high T+7.
REQ-030 Read with pad_din=4'b0110 stable -> rsp_valid single pulse at T+4, rsp_data=4'b0110.
REQ-031 wr_valid and rd_valid held high continuously from reset -> grants alternate W,R,W,R; never both ready same cycle.
REQ-032 resetn pulled low at T+2 of a write -> pad_oe=0 before next clk edge; no rsp_valid; after release first write accepted normally.
REQ-033 Read back-to-back with write driving 4'b1111, pads looped back -> rsp_data=4'b1111 and pad_oe=0 at capture cycle.
REQ-034 DRIVE_CYCLES=1, TURN_CYCLES=1, SETTLE_CYCLES=1 -> write occupies 2 cycles, read response at T+2, counter never underflows.

Source files
------------

// File: rtl/pin_bus_pkg.sv
// Shared state encoding and default timing for the pad bus sequencer.
// The max3 helper sizes the single shared phase counter.
package pin_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_TURN   = 2'd2,
    ST_SETTLE = 2'd3
  } seq_state_e;

  localparam int DEF_NPINS         = 4;
  localparam int DEF_DRIVE_CYCLES  = 4;
  localparam int DEF_TURN_CYCLES   = 2;
  localparam int DEF_SETTLE_CYCLES = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pin_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs.
// Both stages clear to zero on reset.
module pin_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pin_bus_sequencer.sv
// Time-multiplexes a set of shared bidirectional pads between write bursts
// and settled read captures; pad buffers themselves live outside this block.
module pin_bus_sequencer
  import pin_bus_pkg::*;
#(
  parameter int NPINS         = DEF_NPINS,
  parameter int DRIVE_CYCLES  = DEF_DRIVE_CYCLES,
  parameter int TURN_CYCLES   = DEF_TURN_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [NPINS-1:0] wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  output logic             rsp_valid,
  output logic [NPINS-1:0] rsp_data,
  output logic [NPINS-1:0] pad_oe,
  output logic [NPINS-1:0] pad_dout,
  input  logic [NPINS-1:0] pad_din,
  output logic             busy
);

  localparam int MAX_CYCLES = max3(DRIVE_CYCLES, TURN_CYCLES, SETTLE_CYCLES);
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] DRIVE_LOAD  = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  seq_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             prio_wr;
  logic [NPINS-1:0] din_sync;
  logic             idle;
  logic             cnt_done;
  logic             wr_fire;
  logic             rd_fire;

  pin_sync2 #(
    .WIDTH(NPINS)
  ) u_sync (
    .clk   (clk),
    .resetn(resetn),
    .d     (pad_din),
    .q     (din_sync)
  );

  assign idle     = (state == ST_IDLE);
  assign cnt_done = (cnt == '0);
  assign busy     = !idle;

  // Grant decode; resetn gates it so no handshake is offered while held in reset.
  assign wr_ready = resetn && idle && wr_valid && (!rd_valid || prio_wr);
  assign rd_ready = resetn && idle && rd_valid && !(wr_valid && prio_wr);
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;

  // Decoded from the state register so an async reset releases the pads at once.
  assign pad_oe = (state == ST_DRIVE) ? '1 : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      prio_wr   <= 1'b1;
      pad_dout  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_fire) begin
            state    <= ST_DRIVE;
            cnt      <= DRIVE_LOAD;
            pad_dout <= wr_data;
            prio_wr  <= 1'b0;
          end else if (rd_fire) begin
            state   <= ST_SETTLE;
            cnt     <= SETTLE_LOAD;
            prio_wr <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_done) begin
            state <= ST_TURN;
            cnt   <= TURN_LOAD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_TURN: begin
          if (cnt_done) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_SETTLE: begin
          // Capture happens while OE is low, after the full settle window.
          if (cnt_done) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b1;
            rsp_data  <= din_sync;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
